// File: rtl/rope_flash_reader_pkg.sv
// Shared definitions for the rope flash read sequencer.
//  state_t          : sequencer states (IDLE/SETUP/ACCESS/RECOVER)
//  ROPE_ADDR_LIMIT  : first unpopulated rope word address
//  ROPE_DATA_W/ROPE_ADDR_W : flash data and address pin widths
package rope_flash_reader_pkg;

  localparam int unsigned ROPE_DATA_W = 16;
  localparam int unsigned ROPE_ADDR_W = 17;

  localparam logic [15:0] ROPE_ADDR_LIMIT = 16'h4800;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/rope_flash_reader_parity_check.sv
// Odd-parity checker for a captured flash word.
//  data    in  16  word read from the flash DQ pins
//  par_err out 1   high when data holds an even number of ones
module rope_parity_check
  import rope_flash_reader_pkg::*;
(
  input  logic [ROPE_DATA_W-1:0] data,
  output logic                   par_err
);

  // Rope words carry odd parity, so an even popcount is an error.
  assign par_err = ~(^data);

endmodule

// File: rtl/rope_flash_reader.sv
// Single-word read sequencer in front of the SST39VF200A rope flash.
// Accepts one fixed-memory read at a time, runs a timed CE_n/OE_n cycle,
// captures DQ, flags parity errors and returns a registered word.
// Addresses at or above ADDR_LIMIT complete immediately with rd_oor.
//  SIM_CLK, SIM_RST          clock, async active-high reset
//  req_valid/req_addr/req_ready   request handshake (ready only in IDLE)
//  rd_valid/rd_data/rd_par_err/rd_oor   one-cycle response
//  A, CE_n, OE_n, WE_n, DQ   flash pins
module rope_flash_reader
  import rope_flash_reader_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES   = 4,
  parameter int unsigned RECOVERY_CYCLES = 1,
  parameter logic [15:0] ADDR_LIMIT      = ROPE_ADDR_LIMIT
) (
  input  logic                   SIM_CLK,
  input  logic                   SIM_RST,
  input  logic                   req_valid,
  input  logic [15:0]            req_addr,
  output logic                   req_ready,
  output logic                   rd_valid,
  output logic [ROPE_DATA_W-1:0] rd_data,
  output logic                   rd_par_err,
  output logic                   rd_oor,
  output logic [ROPE_ADDR_W-1:0] A,
  output logic                   CE_n,
  output logic                   OE_n,
  output logic                   WE_n,
  input  logic [ROPE_DATA_W-1:0] DQ
);

  localparam int unsigned CNT_MAX = (ACCESS_CYCLES > RECOVERY_CYCLES) ?
                                    ACCESS_CYCLES : RECOVERY_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       addr_q;
  logic              dq_par_err;

  rope_parity_check u_parity (
    .data    (DQ),
    .par_err (dq_par_err)
  );

  assign req_ready = (state == ST_IDLE);
  assign A         = {1'b0, addr_q};
  assign WE_n      = 1'b1;

  // Sequencer: state, wait counter and all registered outputs.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      CE_n       <= 1'b1;
      OE_n       <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_par_err <= 1'b0;
      rd_oor     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_addr >= ADDR_LIMIT) begin
              // Unpopulated address: answer without a flash cycle.
              rd_valid   <= 1'b1;
              rd_data    <= '0;
              rd_par_err <= 1'b0;
              rd_oor     <= 1'b1;
              cnt        <= REC_LOAD;
              state      <= ST_RECOVER;
            end else begin
              addr_q <= req_addr;
              CE_n   <= 1'b0;
              state  <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          OE_n  <= 1'b0;
          cnt   <= ACC_LOAD;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rd_data    <= DQ;
            rd_par_err <= dq_par_err;
            rd_oor     <= 1'b0;
            rd_valid   <= 1'b1;
            CE_n       <= 1'b1;
            OE_n       <= 1'b1;
            cnt        <= REC_LOAD;
            state      <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rope_flash_reader.sv
// Self-checking bench for rope_flash_reader: a timeline model of each
// accepted request predicts every output after every edge; directed
// cases pin the model with literal values, then random traffic follows.
module tb_rope_flash_reader;

  localparam int          ACC = 4;
  localparam int          REC = 1;
  localparam logic [15:0] LIM = 16'h4800;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST = 1'b1;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic        req_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_par_err;
  logic        rd_oor;
  logic [16:0] A;
  logic        CE_n;
  logic        OE_n;
  logic        WE_n;
  logic [15:0] DQ = 16'h0;

  always #5 SIM_CLK = ~SIM_CLK;

  rope_flash_reader #(
    .ACCESS_CYCLES   (ACC),
    .RECOVERY_CYCLES (REC),
    .ADDR_LIMIT      (LIM)
  ) dut (
    .SIM_CLK    (SIM_CLK),
    .SIM_RST    (SIM_RST),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_par_err (rd_par_err),
    .rd_oor     (rd_oor),
    .A          (A),
    .CE_n       (CE_n),
    .OE_n       (OE_n),
    .WE_n       (WE_n),
    .DQ         (DQ)
  );

  // Flash stand-in with one cycle of read latency; garbage when not enabled.
  logic [15:0] mem [0:65535];
  always @(posedge SIM_CLK)
    DQ <= (!CE_n && !OE_n) ? mem[A[15:0]] : 16'hDEAD;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: edge numbers at which each effect of a request appears.
  int          edge_n  = 0;
  int          free_at = 0;
  int          ce_from = 1, ce_to = 0;
  int          oe_from = 1, oe_to = 0;
  int          rd_edge = -1;
  bit          pend    = 1'b0;
  logic [15:0] pend_data = 16'h0;
  logic [15:0] m_data = 16'h0;
  logic        m_perr = 1'b0;
  logic        m_oor  = 1'b0;
  logic [15:0] m_a    = 16'h0;

  always @(posedge SIM_CLK) begin
    edge_n++;
    if (SIM_RST) begin
      free_at = 0; ce_from = 1; ce_to = 0; oe_from = 1; oe_to = 0;
      rd_edge = -1; pend = 1'b0;
      m_data = 16'h0; m_perr = 1'b0; m_oor = 1'b0; m_a = 16'h0;
    end else begin
      if (pend && edge_n == rd_edge) begin
        m_data = pend_data;
        m_perr = ~(^pend_data);
        m_oor  = 1'b0;
        pend   = 1'b0;
      end
      if (req_valid && edge_n >= free_at) begin
        if (req_addr >= LIM) begin
          rd_edge = edge_n;
          m_data  = 16'h0; m_perr = 1'b0; m_oor = 1'b1;
          free_at = edge_n + 1 + REC;
        end else begin
          m_a       = req_addr;
          ce_from   = edge_n;     ce_to = edge_n + ACC;
          oe_from   = edge_n + 1; oe_to = edge_n + ACC;
          rd_edge   = edge_n + 1 + ACC;
          pend      = 1'b1;
          pend_data = mem[req_addr];
          free_at   = edge_n + 2 + ACC + REC;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus pin-protocol invariants.
  logic        prev_ce_low = 1'b0;
  logic        prev_rv     = 1'b0;
  logic [16:0] prev_a      = 17'h0;

  always @(negedge SIM_CLK) begin
    if (SIM_RST) begin
      prev_ce_low = 1'b0;
      prev_rv     = 1'b0;
    end else begin
      chk("req_ready",  req_ready,  (edge_n + 1 >= free_at));
      chk("rd_valid",   rd_valid,   (edge_n == rd_edge));
      chk("rd_data",    rd_data,    m_data);
      chk("rd_par_err", rd_par_err, m_perr);
      chk("rd_oor",     rd_oor,     m_oor);
      chk("A",          A,          {1'b0, m_a});
      chk("CE_n",       CE_n,       !(edge_n >= ce_from && edge_n <= ce_to));
      chk("OE_n",       OE_n,       !(edge_n >= oe_from && edge_n <= oe_to));
      chk("WE_n",       WE_n,       1'b1);
      chk("oe_without_ce", (!OE_n && CE_n), 1'b0);
      chk("rd_valid_back_to_back", (rd_valid && prev_rv), 1'b0);
      if (prev_ce_low && !CE_n) chk("a_stable", A, prev_a);
      prev_ce_low = !CE_n;
      prev_rv     = rd_valid;
      prev_a      = A;
    end
  end

  // Records the edge numbers of the last two rd_valid pulses.
  int last_rv_edge = -100;
  int prev_rv_edge = -100;
  always @(negedge SIM_CLK)
    if (rd_valid) begin
      prev_rv_edge = last_rv_edge;
      last_rv_edge = edge_n;
    end

  task automatic drive_point();
    @(negedge SIM_CLK);
    #1;
  endtask

  // Presents a request and returns just after the edge that accepts it.
  task automatic read_req(input logic [15:0] addr, input bit keep, output int acc_e);
    bit done = 1'b0;
    acc_e = -1;
    drive_point();
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 50 && !done; i++) begin
      if (req_ready) begin
        @(posedge SIM_CLK);
        #1;
        acc_e = edge_n;
        done  = 1'b1;
      end else begin
        drive_point();
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    if (!keep) req_valid = 1'b0;
  endtask

  // Returns the edge number after which rd_valid was seen high.
  task automatic wait_rd(output int e);
    bit done = 1'b0;
    e = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge SIM_CLK);
      #1;
      if (rd_valid) begin
        e    = edge_n;
        done = 1'b1;
      end
    end
    if (!done) chk("rd_valid_timeout", 32'd0, 32'd1);
  endtask

  int  acc, acc2, e;
  bit  last_ready;
  int  sel;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h8001;
    mem[16'h0123] = 16'h0007;

    // Reset state
    repeat (3) @(posedge SIM_CLK);
    drive_point();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_CE_n",      CE_n,      1'b1);
    chk("rst_OE_n",      OE_n,      1'b1);
    chk("rst_rd_valid",  rd_valid,  1'b0);
    chk("rst_A",         A,         17'h0);
    SIM_RST = 1'b0;

    // Word 0x8001 at address 0: even popcount -> parity error
    read_req(16'h0000, 1'b0, acc);
    chk("t1_CE_n_after_E0", CE_n, 1'b0);
    chk("t1_OE_n_after_E0", OE_n, 1'b1);
    @(posedge SIM_CLK); #1;
    chk("t1_OE_n_after_E1", OE_n, 1'b0);
    wait_rd(e);
    chk("t1_latency",    32'(e - acc), 32'd5);
    chk("t1_rd_data",    rd_data,    16'h8001);
    chk("t1_rd_par_err", rd_par_err, 1'b1);
    chk("t1_rd_oor",     rd_oor,     1'b0);

    // Word 0x0007 at 0x0123: odd popcount, and next accept 7 edges on
    read_req(16'h0123, 1'b0, acc);
    wait_rd(e);
    chk("t2_rd_data",    rd_data,    16'h0007);
    chk("t2_rd_par_err", rd_par_err, 1'b0);
    chk("t2_rd_oor",     rd_oor,     1'b0);
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge SIM_CLK); #1;
    end
    chk("t2_next_accept_gap", 32'(edge_n + 1 - acc), 32'd7);

    // Out-of-range requests complete one cycle after accept
    read_req(16'h4800, 1'b0, acc);
    chk("t3a_rd_valid", rd_valid, 1'b1);
    chk("t3a_rd_oor",   rd_oor,   1'b1);
    chk("t3a_rd_data",  rd_data,  16'h0);
    chk("t3a_CE_n",     CE_n,     1'b1);
    read_req(16'hFFFF, 1'b0, acc);
    chk("t3b_rd_valid", rd_valid, 1'b1);
    chk("t3b_rd_oor",   rd_oor,   1'b1);
    chk("t3b_rd_data",  rd_data,  16'h0);
    chk("t3b_par_err",  rd_par_err, 1'b0);

    // Last populated address is still a real read
    read_req(16'h47FF, 1'b0, acc);
    wait_rd(e);
    chk("t3c_rd_oor",  rd_oor,  1'b0);
    chk("t3c_rd_data", rd_data, mem[16'h47FF]);

    // Back-to-back with req_valid held high
    read_req(16'h0010, 1'b1, acc);
    read_req(16'h0011, 1'b0, acc2);
    chk("t4_accept_gap", 32'(acc2 - acc), 32'd7);
    wait_rd(e);
    @(negedge SIM_CLK);
    chk("t4_rd_pulse_gap", 32'(last_rv_edge - prev_rv_edge), 32'd7);
    chk("t4_rd_data", rd_data, mem[16'h0011]);

    // Reset in the middle of ACCESS drops the pins at once
    read_req(16'h0005, 1'b0, acc);
    @(posedge SIM_CLK); #1;
    @(posedge SIM_CLK); #1;
    chk("t5_in_access_OE_n", OE_n, 1'b0);
    #2;
    SIM_RST = 1'b1;
    #1;
    chk("t5_rst_CE_n",      CE_n,      1'b1);
    chk("t5_rst_OE_n",      OE_n,      1'b1);
    chk("t5_rst_rd_valid",  rd_valid,  1'b0);
    chk("t5_rst_req_ready", req_ready, 1'b1);
    repeat (2) @(posedge SIM_CLK);
    drive_point();
    SIM_RST = 1'b0;
    read_req(16'h0001, 1'b0, acc);
    wait_rd(e);
    chk("t5_latency", 32'(e - acc), 32'd5);
    chk("t5_rd_data", rd_data, mem[16'h0001]);

    // Random traffic; requests stay stable until accepted
    last_ready = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive_point();
      if (!req_valid || last_ready) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid = 1'b0;
        end else begin
          req_valid = 1'b1;
          sel = int'($urandom_range(0, 9));
          case (sel)
            0:       req_addr = 16'($urandom_range(32'h4800, 32'hFFFF));
            1:       req_addr = 16'h47FF;
            2:       req_addr = 16'h4800;
            default: req_addr = 16'($urandom_range(0, 32'h47FF));
          endcase
        end
      end
      last_ready = req_ready;
    end
    req_valid = 1'b0;
    repeat (20) @(posedge SIM_CLK);
    @(negedge SIM_CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
